// File: rtl/sram_arb_if.sv
// Request/acknowledge bundle between the recorder/player logic and the SRAM arbiter.
// master = recorder/player side, slave = arbiter side.
interface sram_arb_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    // Handshake: a requester raises req with addr (and data) stable and holds it until its
    // single-cycle ack/valid pulse; addr/data are captured at grant, and a req still high
    // in the following IDLE cycle is taken as a new access.
    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_valid, rd_data, busy
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Serialises recorder writes and player reads onto one async SRAM with a fixed strobe width.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise writes have fixed priority.
module sram_access_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int ACC_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_arb_if.slave         bus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_we_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ACT  = 3'd1,
        WR_HOLD = 3'd2,
        RD_ACT  = 3'd3,
        RD_DONE = 3'd4
    } state_t;

    localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              grant_wr;
    logic              grant_rd;
    logic              drive_dq;
    logic              cnt_zero;

    assign cnt_zero  = (cnt == '0);
    assign dbg_state = state;
    assign sram_addr = addr_q;
    assign sram_dq   = drive_dq ? data_q : {DATA_W{1'bz}};
    assign bus.rd_data = rd_data_q;

`ifdef SRAM_ARB_RR_EN
    logic last_grant_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_wr <= 1'b0;
        end else if (grant_wr) begin
            last_grant_wr <= 1'b1;
        end else if (grant_rd) begin
            last_grant_wr <= 1'b0;
        end
    end

    // Contention goes to the port that was not served last.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == IDLE) begin
            if (bus.wr_req && !(bus.rd_req && last_grant_wr)) begin
                grant_wr = 1'b1;
            end else if (bus.rd_req) begin
                grant_rd = 1'b1;
            end
        end
    end
`else
    // Record data cannot be re-requested later, so a pending write always wins.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == IDLE) begin
            if (bus.wr_req) begin
                grant_wr = 1'b1;
            end else if (bus.rd_req) begin
                grant_rd = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt    = state;
        sram_we_n    = 1'b1;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_lb_n    = 1'b1;
        sram_ub_n    = 1'b1;
        drive_dq     = 1'b0;
        bus.wr_ack   = 1'b0;
        bus.rd_valid = 1'b0;
        bus.busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_nxt = WR_ACT;
                end else if (grant_rd) begin
                    state_nxt = RD_ACT;
                end
            end
            WR_ACT: begin
                sram_ce_n = 1'b0;
                sram_we_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_ub_n = 1'b0;
                drive_dq  = 1'b1;
                if (cnt_zero) begin
                    state_nxt = WR_HOLD;
                end
            end
            WR_HOLD: begin
                // WE_N rises while data and chip select are still held.
                sram_ce_n  = 1'b0;
                sram_lb_n  = 1'b0;
                sram_ub_n  = 1'b0;
                drive_dq   = 1'b1;
                bus.wr_ack = 1'b1;
                state_nxt  = IDLE;
            end
            RD_ACT: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_ub_n = 1'b0;
                if (cnt_zero) begin
                    state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                bus.rd_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant_wr || grant_rd) begin
                cnt    <= CNT_LOAD;
                addr_q <= grant_wr ? bus.wr_addr : bus.rd_addr;
            end else if (!cnt_zero) begin
                cnt <= cnt - 1'b1;
            end
            if (grant_wr) begin
                data_q <= bus.wr_data;
            end
            if (state == RD_ACT && cnt_zero) begin
                rd_data_q <= sram_dq;
            end
        end
    end
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: behavioural SRAM, reference memory map and grant-order model.
module tb_sram_access_arbiter;
    localparam int ACC = 2;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_arb_if #(.ADDR_W(20), .DATA_W(16)) ifc();
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n;
    logic [2:0] dbg_state;

    sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .ACC_CYC(ACC)) dut (
        .clk(clk), .rst(rst), .bus(ifc),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .dbg_state(dbg_state)
    );

    // Behavioural async SRAM
    logic [15:0] sram_mem [0:(1<<20)-1];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_dq;
    end
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_mem [logic [19:0]];
    logic [15:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        ifc.wr_req = 1'b0;
        ifc.rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [19:0] a, input logic [15:0] d);
        int k, we_lo, bad;
        bit got;
        @(negedge clk);
        ifc.wr_req = 1'b1; ifc.wr_addr = a; ifc.wr_data = d;
        k = 0; we_lo = 0; bad = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk); k++;
            if (k == 1) begin
                ifc.wr_addr = a ^ 20'h5A5A5;
                ifc.wr_data = ~d;
            end
            if (!sram_we_n) begin
                we_lo++;
                if (sram_dq !== d || sram_addr !== a || sram_ce_n !== 1'b0) bad++;
            end
            if (ifc.wr_ack) got = 1'b1;
        end
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL wr_timeout: got %0d required 1 (state %0d)", got, dbg_state); end
        n_cmp++; if (k != ACC + 1) begin n_err++; $display("FAIL wr_ack_cycle: got %0d required %0d", k, ACC + 1); end
        n_cmp++; if (we_lo != ACC) begin n_err++; $display("FAIL wr_we_low_cycles: got %0d required %0d", we_lo, ACC); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wr_bus_during_we: got %0d bad cycles required 0", bad); end
        n_cmp++; if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b0) begin n_err++; $display("FAIL wr_hold_strobes: we_n=%b ce_n=%b required 1/0", sram_we_n, sram_ce_n); end
        n_cmp++; if (sram_dq !== d) begin n_err++; $display("FAIL wr_hold_dq: got %h required %h", sram_dq, d); end
        n_cmp++; if (sram_mem[a] !== d) begin n_err++; $display("FAIL wr_sram_word: addr %h got %h required %h", a, sram_mem[a], d); end
        ifc.wr_req = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic do_read(input logic [19:0] a);
        int k, oe_lo, we_lo;
        bit got;
        logic [15:0] exp;
        exp = exp_mem[a];
        @(negedge clk);
        ifc.rd_req = 1'b1; ifc.rd_addr = a;
        k = 0; oe_lo = 0; we_lo = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk); k++;
            if (k == 1) ifc.rd_addr = a ^ 20'hA5A5A;
            if (!sram_oe_n) oe_lo++;
            if (!sram_we_n) we_lo++;
            if (ifc.rd_valid) got = 1'b1;
        end
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL rd_timeout: got %0d required 1 (state %0d)", got, dbg_state); end
        n_cmp++; if (k != ACC + 1) begin n_err++; $display("FAIL rd_valid_cycle: got %0d required %0d", k, ACC + 1); end
        n_cmp++; if (oe_lo != ACC || we_lo != 0) begin n_err++; $display("FAIL rd_strobes: oe_low %0d we_low %0d required %0d/0", oe_lo, we_lo, ACC); end
        n_cmp++; if (ifc.rd_data !== exp) begin n_err++; $display("FAIL rd_data: addr %h got %h required %h", a, ifc.rd_data, exp); end
        ifc.rd_req = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (ifc.wr_ack !== 1'b0 || ifc.rd_valid !== 1'b0 || ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_flags: ack %b valid %b busy %b required 000", ifc.wr_ack, ifc.rd_valid, ifc.busy); end
        n_cmp++; if (ifc.rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data: got %h required 0000", ifc.rd_data); end
        n_cmp++; if (sram_addr !== 20'h0) begin n_err++; $display("FAIL reset_addr: got %h required 00000", sram_addr); end
        n_cmp++; if ({sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n} !== 5'b11111) begin n_err++; $display("FAIL reset_strobes: got %b required 11111", {sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n}); end
        rst = 1'b0;
    endtask

    task automatic test_single_write_read();
        do_write(20'h00010, 16'hBEEF);
        n_cmp++; if (sram_addr !== 20'h00010) begin n_err++; $display("FAIL idle_addr_hold: got %h required 00010", sram_addr); end
        do_read(20'h00010);
    endtask

    task automatic test_arbitration();
        bit ord_q[$];
        int k, n, last_t;
        bit exp_w, last_was_rd;
        logic [15:0] d5, d6;
        d6 = 16'($urandom);
        d5 = 16'($urandom);
        do_write(20'h6, d6);
        apply_reset();
        @(negedge clk);
        ifc.wr_req = 1'b1; ifc.wr_addr = 20'h5; ifc.wr_data = d5;
        ifc.rd_req = 1'b1; ifc.rd_addr = 20'h6;
        k = 0;
        while ((ifc.wr_req || ifc.rd_req) && k < 60) begin
            @(negedge clk); k++;
            if (ifc.wr_ack) begin ord_q.push_back(1'b1); ifc.wr_req = 1'b0; end
            if (ifc.rd_valid) begin
                ord_q.push_back(1'b0); ifc.rd_req = 1'b0;
                n_cmp++; if (ifc.rd_data !== d6) begin n_err++; $display("FAIL arb_rd_data: got %h required %h", ifc.rd_data, d6); end
            end
        end
        exp_mem[20'h5] = d5;
        n_cmp++; if (ord_q.size() != 2) begin n_err++; $display("FAIL arb_count: got %0d required 2", ord_q.size()); end
        if (ord_q.size() == 2) begin
            n_cmp++; if (ord_q[0] !== 1'b1 || ord_q[1] !== 1'b0) begin n_err++; $display("FAIL arb_order: got %b%b required 10 (1=write)", ord_q[0], ord_q[1]); end
        end
        // Both ports held high for eight completions
        apply_reset();
        last_was_rd = 1'b1;
        @(negedge clk);
        ifc.wr_req = 1'b1; ifc.rd_req = 1'b1;
        n = 0; k = 0; last_t = 0;
        while (n < 8 && k < 200) begin
            @(negedge clk); k++;
            if (ifc.wr_ack || ifc.rd_valid) begin
                exp_w = RR ? last_was_rd : 1'b1;
                n_cmp++; if (ifc.wr_ack !== exp_w) begin n_err++; $display("FAIL stall_grant_%0d: write=%b required %b", n, ifc.wr_ack, exp_w); end
                if (ifc.rd_valid) begin
                    n_cmp++; if (ifc.rd_data !== d6) begin n_err++; $display("FAIL stall_rd_data: got %h required %h", ifc.rd_data, d6); end
                end
                if (n > 0) begin
                    n_cmp++; if (k - last_t != ACC + 2) begin n_err++; $display("FAIL stall_spacing: got %0d required %0d", k - last_t, ACC + 2); end
                end
                last_was_rd = !exp_w;
                last_t = k;
                n++;
            end
        end
        n_cmp++; if (n != 8) begin n_err++; $display("FAIL stall_timeout: got %0d completions required 8", n); end
        apply_reset();
    endtask

    task automatic test_reset_mid_write();
        int acks;
        @(negedge clk);
        ifc.wr_req = 1'b1; ifc.wr_addr = 20'h00123; ifc.wr_data = 16'h1234;
        @(negedge clk);
        n_cmp++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL midrst_in_write: we_n %b required 0", sram_we_n); end
        rst = 1'b1;
        #1;
        n_cmp++; if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1) begin n_err++; $display("FAIL midrst_strobes: we_n %b ce_n %b oe_n %b required 111", sram_we_n, sram_ce_n, sram_oe_n); end
        n_cmp++; if (ifc.wr_ack !== 1'b0 || ifc.busy !== 1'b0) begin n_err++; $display("FAIL midrst_flags: ack %b busy %b required 00", ifc.wr_ack, ifc.busy); end
        ifc.wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.wr_ack) acks++;
        end
        n_cmp++; if (acks != 0) begin n_err++; $display("FAIL midrst_no_ack: got %0d acks required 0", acks); end
        do_read(20'h00010);
    endtask

    task automatic test_back_to_back();
        logic [19:0] addrs[$];
        logic [19:0] a;
        logic [15:0] got_exp;
        int k, n, last_t;
        for (int i = 0; i < 6; i++) begin
            a = 20'($urandom_range(0, 20'hFFFFF));
            do_write(a, 16'($urandom));
            addrs.push_back(a);
        end
        @(negedge clk);
        ifc.rd_req = 1'b1; ifc.rd_addr = addrs[0];
        exp_q.push_back(exp_mem[addrs[0]]);
        n = 0; k = 0; last_t = 0;
        while (n < 6 && k < 200) begin
            @(negedge clk); k++;
            if (ifc.rd_valid) begin
                got_exp = exp_q.pop_front();
                n_cmp++; if (ifc.rd_data !== got_exp) begin n_err++; $display("FAIL b2b_data_%0d: got %h required %h", n, ifc.rd_data, got_exp); end
                if (n > 0) begin
                    n_cmp++; if (k - last_t != ACC + 2) begin n_err++; $display("FAIL b2b_spacing: got %0d required %0d", k - last_t, ACC + 2); end
                end
                last_t = k;
                n++;
                if (n < 6) begin
                    ifc.rd_addr = addrs[n];
                    exp_q.push_back(exp_mem[addrs[n]]);
                end else begin
                    ifc.rd_req = 1'b0;
                end
            end
        end
        ifc.rd_req = 1'b0;
        n_cmp++; if (n != 6) begin n_err++; $display("FAIL b2b_timeout: got %0d valids required 6", n); end
        exp_q.delete();
    endtask

    task automatic test_random_mixed();
        logic [19:0] a;
        for (int i = 0; i < 24; i++) begin
            a = 20'h00400 + 20'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1 && exp_mem.exists(a)) do_read(a);
            else do_write(a, 16'($urandom));
        end
    endtask

    initial begin
        ifc.wr_req = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0;
        ifc.rd_req = 1'b0; ifc.rd_addr = '0;
        test_reset();
        test_single_write_read();
        test_arbitration();
        test_reset_mid_write();
        test_back_to_back();
        test_random_mixed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
